gray_decoder_sync: RTL and testbench
====================================

# gray_decoder_sync

Parametrised, registered Gray/binary code converter for board-level inputs such as slide switches or encoders. It synchronises an asynchronous WIDTH-bit input and accepts it only after it has been stable for STABLE_CYCLES samples. The accepted value is converted Gray→binary or binary→Gray, and the registered result drives the LEDs. It is the clocked, width-generic successor of the combinational 4-bit decoder and adds debounce, a new-value strobe, runtime mode selection and Gray-adjacency error detection.

## Interface
- WIDTH, default 4: code width in bits, 2..16.
- STABLE_CYCLES, default 4: number of consecutive identical synchronised samples needed for acceptance, 2..255.
- clk_pi  input  1  system clock; every register updates on its rising edge.
- rst_pi  input  1  reset, synchronous and active-high.
- codigo_in_pi  input  WIDTH  asynchronous input code.
- modo_pi  input  1  asynchronous mode select: 0 = Gray→binary, 1 = binary→Gray.
- clr_error_pi  input  1  synchronous clear for error_po.
- codigo_out_po  output  WIDTH  registered converted code.
- valid_po  output  1  one-cycle pulse when codigo_out_po takes a new value.
- error_po  output  1  sticky Gray-adjacency violation flag.

## Operation
- Synchronisers: codigo_in_pi and modo_pi each pass through a 2-flop synchroniser, giving sync_code and sync_mode. Mode has no debounce.
- Debounce state: candidate register cand[WIDTH-1:0] and saturating counter cnt, sized clog2(STABLE_CYCLES+1).
  - When sync_code ≠ cand: cand ← sync_code and cnt ← 1. The load counts as the first sample.
  - When sync_code = cand and cnt < STABLE_CYCLES: cnt increments.
  - The edge at which cnt goes from STABLE_CYCLES−1 to STABLE_CYCLES is the acceptance edge.
- On the acceptance edge, if cand ≠ accepted:
  - accepted ← cand.
  - codigo_out_po ← conv(cand, mode_q).
  - valid_po ← 1.
- On the acceptance edge, if cand = accepted (input bounced and returned to the accepted value), nothing is updated and valid_po does not pulse.
- Conversions:
  - Gray→binary uses a prefix XOR from the MSB: b[W−1] = g[W−1] and b[i] = b[i+1] ^ g[i].
  - Binary→Gray: g = b ^ (b >> 1).
  - Both are pure combinational functions of WIDTH bits, with no arithmetic carry.
- Mode register mode_q:
  - When sync_mode ≠ mode_q: mode_q ← sync_mode, codigo_out_po ← conv(accepted, sync_mode), valid_po ← 1.
  - If a mode change and an acceptance occur on the same edge, both take effect: output = conv(cand, sync_mode), with a single valid pulse.
- Adjacency check, Gray mode only (mode_q = 0, or the new mode on a simultaneous edge): on acceptance, if popcount(cand ^ accepted) > 1, error_po ← 1. It is never flagged in binary→Gray mode.
- error_po is sticky. clr_error_pi = 1 clears it on the next edge. When set and clear happen on the same edge, set wins.
- Reset, including reset in the middle of a debounce count, clears the following to 0 on the next edge: synchronisers, cand, cnt, accepted, mode_q, codigo_out_po, valid_po, error_po. Any pending candidate is discarded.

## Timing
- Reset values: codigo_out_po = 0, valid_po = 0, error_po = 0. The Gray-adjacency reference after reset is accepted = 0.
- Code latency:
  - The input changes between edges 0 and 1 and then holds.
  - sync_code reflects it after edge 2, and cand loads at edge 3.
  - codigo_out_po and valid_po update at edge STABLE_CYCLES+2 (edge 6 with the default).
- Mode latency: codigo_out_po updates and valid_po pulses at edge 3 after the modo_pi change.
- valid_po is high for exactly one cycle per update and is never high two cycles in a row unless two distinct updates occur.
- Rejection: any change of sync_code before the acceptance edge restarts the count, so a pulse shorter than STABLE_CYCLES samples never reaches the output.
- error_po rises on the same edge as the offending codigo_out_po update.

## Test plan
- Reset with codigo_in_pi = 0000 held → codigo_out_po = 0000, valid_po = 0, error_po = 0 for 20 cycles.
- WIDTH=4, STABLE=4, Gray mode:
  - Apply 0001 → at edge 6, out = 0001 and valid_po pulses once.
  - Then apply 0011 → out = 0010 and error_po stays 0.
  - Then apply 0110 → out = 0100 and error_po = 1.
- Glitch: with 0011 accepted, drive 0111 for 3 cycles, then back to 0011 → no valid_po, out unchanged.
- Mode switch: with 0110 accepted in Gray mode (out = 0100), set modo_pi = 1 → 3 edges later out = 0101, one valid_po pulse. Then apply 0000 → 1111 in binary→Gray mode → out = 1000, error_po unchanged.
- Error clear: with error_po = 1, pulse clr_error_pi → error_po = 0 next edge. Assert clr_error_pi on the same edge as a new adjacency violation → error_po stays 1.
- Reset mid-count: start 1010 and assert rst_pi at edge 4 → all outputs 0. Hold 1010 after release → out updates exactly STABLE+2 edges after release.

Source files
------------

// File: rtl/gray_decoder_sync.sv
// Debounced, synchronised Gray/binary code converter with a new-value strobe
// and a sticky flag for accepted Gray codes that differ in more than one bit.
module gray_decoder_sync #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [WIDTH-1:0] codigo_in_pi,
  input  logic             modo_pi,
  input  logic             clr_error_pi,
  output logic [WIDTH-1:0] codigo_out_po,
  output logic             valid_po,
  output logic             error_po
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] code_meta;
  logic [WIDTH-1:0] sync_code;
  logic             mode_meta;
  logic             sync_mode;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] accepted;
  logic             mode_q;

  logic code_differs;
  logic accept_edge;
  logic new_value;
  logic mode_change;
  logic adjacency_bad;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // mode 0 decodes Gray to binary, mode 1 encodes binary to Gray
  function automatic logic [WIDTH-1:0] convert(input logic [WIDTH-1:0] v, input logic mode);
    return mode ? bin_to_gray(v) : gray_to_bin(v);
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = PW'(0);
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  assign code_differs  = (sync_code != cand);
  assign accept_edge   = !code_differs && (cnt == CNT_LAST);
  assign new_value     = accept_edge && (cand != accepted);
  assign mode_change   = (sync_mode != mode_q);
  assign adjacency_bad = (popcount(cand ^ accepted) > PW'(1));

  // Two-flop synchronisers for the asynchronous code and mode inputs
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      code_meta <= '0;
      sync_code <= '0;
      mode_meta <= 1'b0;
      sync_mode <= 1'b0;
    end else begin
      code_meta <= codigo_in_pi;
      sync_code <= code_meta;
      mode_meta <= modo_pi;
      sync_mode <= mode_meta;
    end
  end

  // Debounce, acceptance, conversion and error tracking
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      cand          <= '0;
      cnt           <= '0;
      accepted      <= '0;
      mode_q        <= 1'b0;
      codigo_out_po <= '0;
      valid_po      <= 1'b0;
      error_po      <= 1'b0;
    end else begin
      // A differing sample reloads the candidate and counts as its first sample
      if (code_differs) begin
        cand <= sync_code;
        cnt  <= CNT_ONE;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      mode_q   <= sync_mode;
      valid_po <= new_value || mode_change;

      if (new_value) begin
        accepted      <= cand;
        codigo_out_po <= convert(cand, sync_mode);
      end else if (mode_change) begin
        codigo_out_po <= convert(accepted, sync_mode);
      end

      // Setting has priority over a simultaneous clear
      if (new_value && !sync_mode && adjacency_bad) begin
        error_po <= 1'b1;
      end else if (clr_error_pi) begin
        error_po <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_decoder_sync.sv
// Directed self-checking bench for gray_decoder_sync (WIDTH=4, STABLE_CYCLES=4).
module tb_gray_decoder_sync;

  logic       clk_pi = 1'b0;
  logic       rst_pi;
  logic [3:0] codigo_in_pi;
  logic       modo_pi;
  logic       clr_error_pi;
  logic [3:0] codigo_out_po;
  logic       valid_po;
  logic       error_po;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  gray_decoder_sync #(.WIDTH(4), .STABLE_CYCLES(4)) dut (
    .clk_pi        (clk_pi),
    .rst_pi        (rst_pi),
    .codigo_in_pi  (codigo_in_pi),
    .modo_pi       (modo_pi),
    .clr_error_pi  (clr_error_pi),
    .codigo_out_po (codigo_out_po),
    .valid_po      (valid_po),
    .error_po      (error_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pi);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a code and expect one update at the sixth edge after the change
  task automatic apply_code(input string tag, input logic [3:0] code,
                            input logic [3:0] exp_out, input logic exp_err);
    codigo_in_pi = code;
    step(5);
    check({tag, " early valid"}, {15'd0, valid_po}, 16'd0);
    step(1);
    check({tag, " out"}, {12'd0, codigo_out_po}, {12'd0, exp_out});
    check({tag, " valid"}, {15'd0, valid_po}, 16'd1);
    check({tag, " error"}, {15'd0, error_po}, {15'd0, exp_err});
    step(1);
    check({tag, " valid single"}, {15'd0, valid_po}, 16'd0);
  endtask

  initial begin
    rst_pi       = 1'b1;
    codigo_in_pi = 4'b0000;
    modo_pi      = 1'b0;
    clr_error_pi = 1'b0;
    step(3);
    check("reset out", {12'd0, codigo_out_po}, 16'd0);
    check("reset valid", {15'd0, valid_po}, 16'd0);
    check("reset error", {15'd0, error_po}, 16'd0);
    rst_pi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("idle out", {12'd0, codigo_out_po}, 16'd0);
      check("idle valid", {15'd0, valid_po}, 16'd0);
      check("idle error", {15'd0, error_po}, 16'd0);
    end

    // Gray decoding of adjacent codes
    apply_code("g0001", 4'b0001, 4'b0001, 1'b0);
    apply_code("g0011", 4'b0011, 4'b0010, 1'b0);

    // Three-sample glitch to 0111 then back: never accepted
    codigo_in_pi = 4'b0111;
    step(3);
    codigo_in_pi = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      step(1);
      check("glitch valid", {15'd0, valid_po}, 16'd0);
    end
    check("glitch out", {12'd0, codigo_out_po}, 16'h0002);

    // Two-bit jump raises the adjacency error
    apply_code("g0110", 4'b0110, 4'b0100, 1'b1);

    // Switch to binary->Gray: re-encode accepted 0110
    modo_pi = 1'b1;
    step(2);
    check("mode early valid", {15'd0, valid_po}, 16'd0);
    step(1);
    check("mode out", {12'd0, codigo_out_po}, 16'h0005);
    check("mode valid", {15'd0, valid_po}, 16'd1);
    step(1);
    check("mode valid single", {15'd0, valid_po}, 16'd0);
    apply_code("b0000", 4'b0000, 4'b0000, 1'b1);
    apply_code("b1111", 4'b1111, 4'b1000, 1'b1);

    // Plain clear
    clr_error_pi = 1'b1;
    step(1);
    clr_error_pi = 1'b0;
    check("clear error", {15'd0, error_po}, 16'd0);

    // Back to Gray mode: decode accepted 1111
    modo_pi = 1'b0;
    step(3);
    check("gray mode out", {12'd0, codigo_out_po}, 16'h000A);
    check("gray mode valid", {15'd0, valid_po}, 16'd1);
    check("gray mode error", {15'd0, error_po}, 16'd0);

    // Violation 1111 -> 0000 with clear on the same edge: set wins
    codigo_in_pi = 4'b0000;
    step(5);
    clr_error_pi = 1'b1;
    step(1);
    clr_error_pi = 1'b0;
    check("set-vs-clr error", {15'd0, error_po}, 16'd1);
    check("set-vs-clr out", {12'd0, codigo_out_po}, 16'd0);
    check("set-vs-clr valid", {15'd0, valid_po}, 16'd1);

    // Reset in the middle of a debounce count
    codigo_in_pi = 4'b1010;
    step(3);
    rst_pi = 1'b1;
    step(1);
    rst_pi = 1'b0;
    check("midrst out", {12'd0, codigo_out_po}, 16'd0);
    check("midrst valid", {15'd0, valid_po}, 16'd0);
    check("midrst error", {15'd0, error_po}, 16'd0);
    step(5);
    check("post-rst early valid", {15'd0, valid_po}, 16'd0);
    check("post-rst early out", {12'd0, codigo_out_po}, 16'd0);
    step(1);
    check("post-rst out", {12'd0, codigo_out_po}, 16'h000C);
    check("post-rst valid", {15'd0, valid_po}, 16'd1);
    check("post-rst error", {15'd0, error_po}, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
